// File: rtl/vector_alu_seq.sv
// vector_alu_seq: multi-cycle vector ALU over a whole register group.
// Processes LANE_NUM element slots per EXEC cycle. Honours vl, SEW,
// the v0 mask and undisturbed tail/inactive policy. Covers the
// add/sub, carry-mask and multiply-accumulate op families.

`ifndef ONE_BYTE
`define ONE_BYTE    3'b000
`define TWO_BYTE    3'b001
`define FOUR_BYTE   3'b010
`define EIGHT_BYTE  3'b011
`endif

`ifndef VECTOR_ADD
`define VECTOR_ADD   6'b000000
`define VECTOR_SUB   6'b000010
`define VECTOR_ADC   6'b010000
`define VECTOR_MADC  6'b010001
`define VECTOR_SBC   6'b010010
`define VECTOR_MSBC  6'b010011
`define VECTOR_MADD  6'b101001
`define VECTOR_MACC  6'b101101
`define VECTOR_NMSAC 6'b101111
`endif

module vector_alu_seq #(
    parameter int LONGEST_LEN      = 64,
    parameter int VECTOR_SIZE      = 8,
    parameter int ENTRY_INDEX_SIZE = 3,
    parameter int LANE_NUM         = 2,
    parameter int VL_WIDTH         = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    output logic                              busy,
    input  logic [VL_WIDTH-1:0]               vl,
    input  logic [2:0]                        vsew,
    input  logic                              vm,
    input  logic [5:0]                        opcode,
    input  logic [VECTOR_SIZE*LONGEST_LEN-1:0] vs1,
    input  logic [VECTOR_SIZE*LONGEST_LEN-1:0] vs2,
    input  logic [VECTOR_SIZE*LONGEST_LEN-1:0] vd_old,
    input  logic [VECTOR_SIZE-1:0]            mask_in,
    output logic [VECTOR_SIZE*LONGEST_LEN-1:0] result,
    output logic [VECTOR_SIZE-1:0]            mask_result,
    output logic                              done
);

    localparam int L = LONGEST_LEN;
    localparam logic [VL_WIDTH-1:0] LANE_STEP = VL_WIDTH'(LANE_NUM);
    localparam logic [VL_WIDTH-1:0] VL_MAX    = VL_WIDTH'(VECTOR_SIZE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Per-lane outcome: optional element write and optional mask-bit write.
    typedef struct packed {
        logic         wr;
        logic [L-1:0] val;
        logic         mwr;
        logic         mbit;
    } lane_out_t;

    state_t state, state_next;

    logic [VL_WIDTH-1:0]                 idx;
    logic [VL_WIDTH-1:0]                 vl_q;
    logic [2:0]                          sew_q;
    logic                                vm_q;
    logic [5:0]                          op_q;
    logic [VECTOR_SIZE-1:0][L-1:0]       vs1_q;
    logic [VECTOR_SIZE-1:0][L-1:0]       vs2_q;
    logic [VECTOR_SIZE-1:0]              mask_q;
    logic [VECTOR_SIZE-1:0][L-1:0]       result_q;
    logic [VECTOR_SIZE-1:0]              mask_result_q;

    lane_out_t                           lanes     [LANE_NUM];
    logic [ENTRY_INDEX_SIZE-1:0]         lane_slot [LANE_NUM];
    logic                                last_beat;

    assign result      = result_q;
    assign mask_result = mask_result_q;

    // The idx+LANE_STEP sum never exceeds VECTOR_SIZE, so it fits vl's width.
    assign last_beat = (idx + LANE_STEP) >= vl_q;

    // One element: operands are reduced to SEW bits, the result zero-extended.
    // The accumulator/undisturbed value c is the element's current result slot,
    // which still holds vd_old because each slot is visited exactly once.
    function automatic lane_out_t lane_op(
        input logic [5:0]   op,
        input logic [2:0]   sew,
        input logic [L-1:0] a,
        input logic [L-1:0] b,
        input logic [L-1:0] c,
        input logic         m,
        input logic         vmask,
        input logic         in_vl
    );
        lane_out_t   o;
        int unsigned w;
        logic [L-1:0] msk, am, bm, cm;
        logic [L:0]   wide;
        logic         ci;
        logic         act;
        o    = '0;
        wide = '0;
        case (sew)
            `ONE_BYTE:   w = 8;
            `TWO_BYTE:   w = 16;
            `FOUR_BYTE:  w = 32;
            `EIGHT_BYTE: w = 64;
            default:     w = 0;
        endcase
        if (w == 0 || w > L) begin
            return '0;
        end
        msk = {L{1'b1}} >> (L - w);
        am  = a & msk;
        bm  = b & msk;
        cm  = c & msk;
        ci  = vmask & m;
        act = in_vl && (!vmask || m);
        case (op)
            `VECTOR_ADD: begin
                o.wr  = act;
                o.val = (bm + am) & msk;
            end
            `VECTOR_SUB: begin
                o.wr  = act;
                o.val = (bm - am) & msk;
            end
            `VECTOR_ADC: begin
                o.wr  = in_vl;
                o.val = (bm + am + L'(m)) & msk;
            end
            `VECTOR_SBC: begin
                o.wr  = in_vl;
                o.val = (bm - am - L'(m)) & msk;
            end
            `VECTOR_MADC: begin
                wide   = {1'b0, bm} + {1'b0, am} + (L+1)'(ci);
                o.mwr  = in_vl;
                o.mbit = (wide >> w) != '0;
            end
            `VECTOR_MSBC: begin
                // Zero-extended operands: a negative difference sets the top bit.
                wide   = {1'b0, bm} - {1'b0, am} - (L+1)'(ci);
                o.mwr  = in_vl;
                o.mbit = wide[L];
            end
            `VECTOR_MACC: begin
                o.wr  = act;
                o.val = (cm + am * bm) & msk;
            end
            `VECTOR_NMSAC: begin
                o.wr  = act;
                o.val = (cm - am * bm) & msk;
            end
            `VECTOR_MADD: begin
                o.wr  = act;
                o.val = (am * cm + bm) & msk;
            end
            default: o = '0;
        endcase
        return o;
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of process ordering.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = EXEC;
            end
            EXEC: begin
                busy = 1'b1;
                if (last_beat) state_next = FIN;
            end
            FIN: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture on an accepted start.
    always_ff @(posedge clk) begin
        // NOTE: operand registers carry no reset; they are always loaded on
        // start before EXEC reads them, so reset would only add fan-out.
        if (state == IDLE && start) begin
            vl_q   <= (vl > VL_MAX) ? VL_MAX : vl;
            sew_q  <= vsew;
            vm_q   <= vm;
            op_q   <= opcode;
            vs1_q  <= vs1;
            vs2_q  <= vs2;
            mask_q <= mask_in;
        end
    end

    // Lane evaluation for the slots addressed by idx this cycle.
    always_comb begin
        for (int l = 0; l < LANE_NUM; l++) begin
            logic [VL_WIDTH-1:0] elem;
            elem         = idx + VL_WIDTH'(l);
            lane_slot[l] = elem[ENTRY_INDEX_SIZE-1:0];
            lanes[l]     = lane_op(op_q, sew_q,
                                   vs1_q[lane_slot[l]], vs2_q[lane_slot[l]],
                                   result_q[lane_slot[l]], mask_q[lane_slot[l]],
                                   vm_q, elem < vl_q);
        end
    end

    // Result/mask registers and element index.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q      <= '0;
            mask_result_q <= '0;
            idx           <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        result_q      <= vd_old;
                        mask_result_q <= '0;
                        idx           <= '0;
                    end
                end
                EXEC: begin
                    for (int l = 0; l < LANE_NUM; l++) begin
                        if (lanes[l].wr)  result_q[lane_slot[l]]      <= lanes[l].val;
                        if (lanes[l].mwr) mask_result_q[lane_slot[l]] <= lanes[l].mbit;
                    end
                    idx <= idx + LANE_STEP;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vector_alu_seq.sv
// tb_vector_alu_seq: directed, hand-computed vectors for vector_alu_seq.
module tb_vector_alu_seq;

    // Encodings shared with the design's codebase macros.
    localparam logic [2:0] SEW8  = 3'b000;
    localparam logic [2:0] SEW16 = 3'b001;
    localparam logic [2:0] SEW32 = 3'b010;
    localparam logic [2:0] SEW64 = 3'b011;
    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000010;
    localparam logic [5:0] OP_ADC   = 6'b010000;
    localparam logic [5:0] OP_MADC  = 6'b010001;
    localparam logic [5:0] OP_MSBC  = 6'b010011;
    localparam logic [5:0] OP_MADD  = 6'b101001;
    localparam logic [5:0] OP_MACC  = 6'b101101;
    localparam logic [5:0] OP_NMSAC = 6'b101111;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             busy;
    logic [3:0]       vl;
    logic [2:0]       vsew;
    logic             vm;
    logic [5:0]       opcode;
    logic [7:0][63:0] vs1, vs2, vd_old, result;
    logic [7:0]       mask_in, mask_result;
    logic             done;

    int checks = 0;
    int errors = 0;

    vector_alu_seq dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .vl(vl),
        .vsew(vsew), .vm(vm), .opcode(opcode), .vs1(vs1), .vs2(vs2),
        .vd_old(vd_old), .mask_in(mask_in), .result(result),
        .mask_result(mask_result), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait for done; n0 is the cycle count already elapsed since start.
    task automatic wait_done(input string tag, input int n0, input int exp_lat);
        int n;
        n = n0;
        while (!done && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, 64'(n), 64'(exp_lat));
    endtask

    // Pulse start for one edge and check done latency.
    task automatic run(input string tag, input int exp_lat);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(tag, 1, exp_lat);
    endtask

    task automatic fill(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        for (int i = 0; i < 8; i++) begin
            vs1[i] = a; vs2[i] = b; vd_old[i] = c;
        end
    endtask

    initial begin
        logic saw_done;
        rst = 1'b1; start = 1'b0; vl = '0; vsew = SEW8; vm = 1'b0;
        opcode = OP_ADD; mask_in = '0;
        fill(64'h0, 64'h0, 64'h0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_result", result[0] | result[7], 64'd0);
        check("rst_mask", 64'(mask_result), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // ADD 8-bit, high garbage bits ignored, wrap to 0x10.
        fill(64'hFFFF_0000_0000_00F0, 64'h1234_0000_0000_0020, 64'h5555);
        vl = 4'd8; vsew = SEW8; vm = 1'b0; opcode = OP_ADD;
        run("add_latency", 5);
        for (int i = 0; i < 8; i++) check($sformatf("add_slot%0d", i), result[i], 64'h10);
        @(posedge clk); #1;
        check("add_done_one_cycle", 64'(done), 64'd0);
        check("add_idle_busy", 64'(busy), 64'd0);
        check("add_hold", result[3], 64'h10);

        // SUB 32-bit masked, vl=5: slots 0,2,4 active; wrap to FFFF_FFF8.
        fill(64'h1234_5678_0000_0010, 64'h0000_0000_0000_0008, 64'hAA);
        vl = 4'd5; vsew = SEW32; vm = 1'b1; mask_in = 8'b0001_0101; opcode = OP_SUB;
        run("sub_latency", 4);
        for (int i = 0; i < 8; i++)
            check($sformatf("sub_slot%0d", i), result[i],
                  (i == 0 || i == 2 || i == 4) ? 64'hFFFF_FFF8 : 64'hAA);
        @(posedge clk); #1;

        // MADC 16-bit, no carry-in; tail slots would carry but are past vl.
        fill(64'hFFFF, 64'hFFFF, 64'h0);
        vs2[0] = 64'h1; vs2[1] = 64'h0; vs2[2] = 64'hFFFF; vs2[3] = 64'h0;
        for (int i = 0; i < 8; i++) vd_old[i] = 64'h100 + 64'(i);
        vl = 4'd4; vsew = SEW16; vm = 1'b0; mask_in = 8'hFF; opcode = OP_MADC;
        run("madc_latency", 3);
        check("madc_mask", 64'(mask_result), 64'b0000_0101);
        check("madc_result0", result[0], 64'h100);
        check("madc_result6", result[6], 64'h106);
        @(posedge clk); #1;

        // MADC with carry-in on slot 1: 0+FFFF+1 now carries.
        vm = 1'b1; mask_in = 8'b0000_0010;
        run("madc_ci_latency", 3);
        check("madc_ci_mask", 64'(mask_result), 64'b0000_0111);
        @(posedge clk); #1;

        // MSBC same operands, no borrow-in: 1-FFFF, 0-FFFF, 0-FFFF borrow.
        vm = 1'b0; opcode = OP_MSBC;
        run("msbc_latency", 3);
        check("msbc_mask", 64'(mask_result), 64'b0000_1011);
        @(posedge clk); #1;

        // MACC / NMSAC 64-bit, vl=3.
        fill(64'd3, 64'd5, 64'd7);
        vl = 4'd3; vsew = SEW64; vm = 1'b0; opcode = OP_MACC;
        run("macc_latency", 3);
        check("macc_slot0", result[0], 64'd22);
        check("macc_slot2", result[2], 64'd22);
        check("macc_slot3", result[3], 64'd7);
        @(posedge clk); #1;
        opcode = OP_NMSAC;
        run("nmsac_latency", 3);
        check("nmsac_slot1", result[1], 64'hFFFF_FFFF_FFFF_FFF8);
        check("nmsac_slot5", result[5], 64'd7);
        @(posedge clk); #1;

        // MADD 64-bit, vl above VECTOR_SIZE clamps to 8: 3*7+5 = 26.
        vl = 4'd15; opcode = OP_MADD;
        run("madd_clamp_latency", 5);
        check("madd_slot0", result[0], 64'd26);
        check("madd_slot7", result[7], 64'd26);
        @(posedge clk); #1;

        // ADC 8-bit, vm ignored for activity; mask bits are carry-in.
        fill(64'hFF, 64'h01, 64'h77);
        vl = 4'd8; vsew = SEW8; vm = 1'b0; mask_in = 8'b1010_1010; opcode = OP_ADC;
        run("adc_latency", 5);
        check("adc_slot0", result[0], 64'h00);
        check("adc_slot1", result[1], 64'h01);
        @(posedge clk); #1;

        // Unknown opcode: nothing written but done still pulses.
        opcode = 6'b111111;
        run("badop_latency", 5);
        check("badop_slot4", result[4], 64'h77);
        @(posedge clk); #1;

        // Unknown vsew.
        opcode = OP_ADD; vsew = 3'b111;
        run("badsew_latency", 5);
        check("badsew_slot2", result[2], 64'h77);
        @(posedge clk); #1;

        // vl=0: one EXEC cycle, result = vd_old.
        fill(64'h1, 64'h2, 64'h99);
        vl = 4'd0; vsew = SEW8; opcode = OP_ADD;
        run("vl0_latency", 2);
        check("vl0_slot0", result[0], 64'h99);
        @(posedge clk); #1;

        // Start pulsed during EXEC is ignored; start in DONE is ignored.
        fill(64'h1, 64'h2, 64'h11);
        vl = 4'd8;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        vs1[0] = 64'h40; vd_old[0] = 64'h22; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("exec_start_latency", 2, 5);
        check("exec_start_slot0", result[0], 64'h3);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("done_start_ignored", 64'(busy), 64'd0);
        @(posedge clk); #1;

        // Reset in the second EXEC cycle aborts without done.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_result", result[0], 64'd0);
        saw_done = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            saw_done = saw_done | done;
        end
        check("abort_no_done", 64'(saw_done), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vector_alu_seq.md
Name: vector_alu_seq

Overview:
- Multi-cycle, parametrised successor to the single-element vector ALU.
- Accepts a whole vector register group (VECTOR_SIZE element slots, each LONGEST_LEN bits) and processes LANE_NUM elements per cycle.
- Honours vl, SEW, v0 mask and tail policy, and implements the carry-mask and multiply-accumulate ops (MADC, MSBC, MACC, NMSAC, MADD) in addition to ADD/SUB/ADC/SBC.
- Sits between the vector register file read stage and writeback, with a start/done handshake toward the issue controller.

Parameters:
- LONGEST_LEN, 64, width of one element slot (max SEW).
- VECTOR_SIZE, 8, element slots per vector operand.
- ENTRY_INDEX_SIZE, 3, log2(VECTOR_SIZE).
- LANE_NUM, 2, elements processed per cycle; must divide VECTOR_SIZE.
- VL_WIDTH, 4, width of vl (must hold VECTOR_SIZE).

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, launch operation; sampled only in IDLE.
- busy, output, 1, high from the cycle after an accepted start until DONE exits.
- vl, input, VL_WIDTH, active element count; values above VECTOR_SIZE are clamped.
- vsew, input, 3, `ONE_BYTE/`TWO_BYTE/`FOUR_BYTE/`EIGHT_BYTE.
- vm, input, 1, 1 = masked by mask_in (codebase convention).
- opcode, input, 6, `VECTOR_ADD/SUB/ADC/SBC/MADC/MSBC/MACC/NMSAC/MADD.
- vs1, input, VECTOR_SIZE*LONGEST_LEN, source 1.
- vs2, input, VECTOR_SIZE*LONGEST_LEN, source 2.
- vd_old, input, VECTOR_SIZE*LONGEST_LEN, prior destination value (accumulator and undisturbed source).
- mask_in, input, VECTOR_SIZE, v0 mask bits, bit i for element i.
- result, output, VECTOR_SIZE*LONGEST_LEN, element results.
- mask_result, output, VECTOR_SIZE, carry/borrow mask for MADC/MSBC.
- done, output, 1, one-cycle pulse; result and mask_result are valid and held until the next start.

Behaviour:
- Reset: state IDLE; busy=0, done=0, result=0, mask_result=0, element index=0. Reset mid-operation aborts the operation with no done pulse.

Operand capture:
- On start in IDLE, latch all inputs.
- Preload the result register with vd_old and mask_result with 0.
- Go to EXEC. start while busy or in DONE is ignored.

EXEC:
- Each cycle processes elements idx..idx+LANE_NUM-1; idx then advances by LANE_NUM.
- Leave for DONE once idx+LANE_NUM >= clamped vl. Latency = ceil(vl/LANE_NUM) EXEC cycles + 1 DONE cycle.
- vl=0: one EXEC cycle with no element written, then DONE, so result = vd_old.

DONE:
- done=1 for exactly one cycle, then IDLE.
- start is accepted in the IDLE cycle after done, never in the DONE cycle.

Element rules (per element i):
- Operands are the low SEW bits of each slot. Computation is modulo 2^SEW, and the result is zero-extended to LONGEST_LEN.
- Active element: i < vl and (vm=0 or mask_in[i]=1).
- Inactive and tail elements keep vd_old[i] (undisturbed). The mask_result bit keeps 0.
- ADD: vs2+vs1. SUB: vs2-vs1.
- ADC: vs2+vs1+mask_in[i]. SBC: vs2-vs1-mask_in[i]. For ADC and SBC, mask_in is a data input and every i < vl is active regardless of vm.
- MADC: mask_result[i] = carry-out of vs2+vs1 (+mask_in[i] when vm=1). result is unchanged.
- MSBC: mask_result[i] = borrow of vs2-vs1 (-mask_in[i] when vm=1). result is unchanged.
- MACC: vd_old+vs1*vs2. NMSAC: vd_old-vs1*vs2. MADD: vs1*vd_old+vs2.
- Products use the low SEW bits of an SEW×SEW multiply.
- Unknown opcode or vsew: treat every element as inactive. The operation still completes with a done pulse.

Test Plan:
- ADD, SEW=`ONE_BYTE, vl=8, vm=0, vs1[i]=0xF0, vs2[i]=0x20 → every result slot = 0x10; done asserted 5 cycles after start with LANE_NUM=2.
- SUB, SEW=`FOUR_BYTE, vl=5, vm=1, mask_in=8'b0001_0101, vd_old slots=0xAA → slots 0, 2, 4 = vs2-vs1; slots 1, 3 and 5-7 = 0xAA.
- MADC, SEW=`TWO_BYTE, vl=4, vs1=0xFFFF, vs2={1,0,0xFFFF,0} → mask_result=8'b0000_0101; result = vd_old.
- MACC, SEW=`EIGHT_BYTE, vl=3, vs1=3, vs2=5, vd_old=7 → slots 0-2 = 22; NMSAC with the same inputs → 0xFFFF_FFFF_FFFF_FFF8.
- vl=0 start → done 2 cycles after start; result = vd_old. A start pulsed during EXEC is ignored.
- rst asserted in the second EXEC cycle → next cycle busy=0, result=0, and no done pulse.
